sine_monitor: RTL and testbench

Receive-side checker for the DSM DAC sample path. It consumes the 16-bit signed sample stream that the sine source produces at the `clk_en` rate. It measures the waveform period in samples, its positive and negative peaks, and whether the period is stable. It sits beside the modulator input as a built-in self-test monitor and presents registered results for readout.

---
 rtl/sine_monitor.sv | 131 +++++++++++++
 tb/tb_sine_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sine_monitor.sv
// Built-in self-test monitor for the DSM DAC sample path: measures period,
// peak levels and period stability of a signed 16-bit sine sample stream.
module sine_monitor #(
    parameter int PERIOD_WIDTH = 16,
    parameter int MAX_PERIOD   = 65535,
    parameter int HYST         = 512,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [15:0]      in,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic signed [15:0]      peak_pos,
    output logic signed [15:0]      peak_neg,
    output logic                    meas_valid,
    output logic                    locked,
    output logic                    timeout
);

    localparam int LockWidth = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_WIDTH-1:0] MaxCnt   = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic signed [15:0]      NegHyst  = 16'(-HYST);
    localparam logic [LockWidth-1:0]    LockFull = LockWidth'(LOCK_COUNT);

    typedef enum logic {Search, Measure} state_t;

    state_t                  state_q;
    logic                    armed_q;
    logic                    firstMeas_q;
    logic signed [15:0]      prev_q;
    logic signed [15:0]      maxT_q;
    logic signed [15:0]      minT_q;
    logic signed [15:0]      peakPos_q;
    logic signed [15:0]      peakNeg_q;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [LockWidth-1:0]    lockCnt_q;
    logic [LockWidth-1:0]    lockCnt_d;
    logic                    measValid_q;
    logic                    locked_q;
    logic                    timeout_q;
    logic                    crossing;
    logic                    armTrig;

    // A rising zero crossing only counts once the signal has swung below -HYST.
    assign crossing  = armed_q && (prev_q < 16'sd0) && (in >= 16'sd0);
    assign armTrig   = (in <= NegHyst);
    assign lockCnt_d = (lockCnt_q == LockFull) ? lockCnt_q : lockCnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= Search;
            armed_q     <= 1'b0;
            firstMeas_q <= 1'b0;
            prev_q      <= '0;
            maxT_q      <= '0;
            minT_q      <= '0;
            peakPos_q   <= '0;
            peakNeg_q   <= '0;
            cnt_q       <= '0;
            period_q    <= '0;
            lockCnt_q   <= '0;
            measValid_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            measValid_q <= 1'b0;
            if (clk_en) begin
                prev_q <= in;
                if (crossing) begin
                    armed_q <= 1'b0;
                end else if (armTrig) begin
                    armed_q <= 1'b1;
                end
                case (state_q)
                    Search: begin
                        // The cycle in progress at entry is partial, so only start counting.
                        if (crossing) begin
                            cnt_q       <= PERIOD_WIDTH'(1);
                            maxT_q      <= in;
                            minT_q      <= in;
                            firstMeas_q <= 1'b1;
                            state_q     <= Measure;
                        end
                    end
                    Measure: begin
                        if (crossing) begin
                            period_q    <= cnt_q;
                            peakPos_q   <= maxT_q;
                            peakNeg_q   <= minT_q;
                            measValid_q <= 1'b1;
                            timeout_q   <= 1'b0;
                            cnt_q       <= PERIOD_WIDTH'(1);
                            maxT_q      <= in;
                            minT_q      <= in;
                            firstMeas_q <= 1'b0;
                            if (cnt_q != period_q) begin
                                lockCnt_q <= '0;
                                locked_q  <= 1'b0;
                            end else if (!firstMeas_q) begin
                                lockCnt_q <= lockCnt_d;
                                locked_q  <= (lockCnt_d == LockFull);
                            end
                        end else if (cnt_q == MaxCnt) begin
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            lockCnt_q <= '0;
                            armed_q   <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= Search;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (in > maxT_q) maxT_q <= in;
                            if (in < minT_q) minT_q <= in;
                        end
                    end
                    default: state_q <= Search;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign peak_pos   = peakPos_q;
    assign peak_neg   = peakNeg_q;
    assign meas_valid = measValid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sine_monitor.sv
// Scoreboard bench for sine_monitor: directed sine, noise, timeout, period
// change and reset scenarios with hand-derived expected measurements.
`timescale 1ns/1ps
module tb_sine_monitor;

    localparam real PI = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic signed [15:0] inS;
    logic [15:0]        period;
    logic signed [15:0] peak_pos;
    logic signed [15:0] peak_neg;
    logic               meas_valid;
    logic               locked;
    logic               timeout;

    sine_monitor #(
        .PERIOD_WIDTH(16),
        .MAX_PERIOD  (100),
        .HYST        (512),
        .LOCK_COUNT  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .in        (inS),
        .period    (period),
        .peak_pos  (peak_pos),
        .peak_neg  (peak_neg),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int pos;
        int neg;
        bit lk;
        bit to;
    } meas_t;

    meas_t expQ[$];
    int    assertCount = 0;
    int    failCount   = 0;
    int    sine50[50];
    int    sine40[40];
    int    max40;
    int    min40;
    int    triWave[12] = '{0, 100, 200, 300, 200, 100, 0, -100, -200, -300, -200, -100};
    bit    lastValid = 1'b0;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int per, input int pos, input int neg, input bit lk, input bit to);
        meas_t e;
        e.per = per;
        e.pos = pos;
        e.neg = neg;
        e.lk  = lk;
        e.to  = to;
        expQ.push_back(e);
    endtask

    task automatic driveSample(input int v, input int gap);
        inS    = 16'(v);
        clk_en = 1'b1;
        @(posedge clk); #1;
        clk_en = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input int len, input int gap, input int firstIdx, input int lastIdx);
        for (int i = firstIdx; i <= lastIdx; i++) begin
            driveSample((len == 50) ? sine50[i] : sine40[i], gap);
        end
    endtask

    // Every measurement pulse must match the next queued expectation and last one clock.
    always @(negedge clk) begin : monitor
        meas_t e;
        if (lastValid) checkOutput("meas_valid_width", meas_valid, 0);
        if (meas_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_meas: got meas_valid=1 period=%0d, expected no measurement", period);
            end else begin
                e = expQ.pop_front();
                checkOutput("period", period, e.per);
                checkOutput("peak_pos", peak_pos, e.pos);
                checkOutput("peak_neg", peak_neg, e.neg);
                checkOutput("locked", locked, e.lk);
                checkOutput("timeout", timeout, e.to);
            end
        end
        lastValid = (meas_valid === 1'b1);
    end

    initial begin
        rst    = 1'b0;
        clk_en = 1'b0;
        inS    = '0;
        for (int i = 0; i < 50; i++)
            sine50[i] = $rtoi($floor(16384.0 * $sin(2.0 * PI * (real'(i) + 0.5) / 50.0) + 0.5));
        for (int i = 0; i < 40; i++)
            sine40[i] = $rtoi($floor(16384.0 * $sin(2.0 * PI * (real'(i) + 0.5) / 40.0) + 0.5));
        max40 = sine40[0];
        min40 = sine40[0];
        for (int i = 1; i < 40; i++) begin
            if (sine40[i] > max40) max40 = sine40[i];
            if (sine40[i] < min40) min40 = sine40[i];
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checkOutput("rst_period", period, 0);
        checkOutput("rst_peak_pos", peak_pos, 0);
        checkOutput("rst_peak_neg", peak_neg, 0);
        checkOutput("rst_meas_valid", meas_valid, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_timeout", timeout, 0);

        // Dither that never reaches -HYST must never arm the crossing detector.
        for (int r = 0; r < 20; r++)
            for (int k = 0; k < 12; k++) driveSample(triWave[k], 0);
        checkOutput("noise_timeout", timeout, 0);
        checkOutput("noise_period", period, 0);

        // Continuous strobe: crossings at the start of periods 1..6, measurements from period 2.
        for (int p = 0; p < 7; p++) begin
            if (p >= 2) pushExp(50, 16384, -16384, (p - 1) >= 5, 1'b0);
            applyStimulus(50, 0, 0, 49);
        end
        checkOutput("lock_continuous", locked, 1);

        // Switch to 40 samples per period while locked.
        for (int q = 0; q < 6; q++) begin
            if (q == 0) pushExp(50, 16384, -16384, 1'b1, 1'b0);
            else        pushExp(40, max40, min40, q == 5, 1'b0);
            applyStimulus(40, 0, 0, 39);
        end
        pushExp(40, max40, min40, 1'b1, 1'b0);
        applyStimulus(40, 0, 0, 9);
        checkOutput("relock_40", locked, 1);

        // One-clock reset in the middle of a locked cycle.
        inS    = 16'(sine40[10]);
        clk_en = 1'b1;
        rst    = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b1;
        clk_en = 1'b0;
        checkOutput("midrst_period", period, 0);
        checkOutput("midrst_peak_pos", peak_pos, 0);
        checkOutput("midrst_peak_neg", peak_neg, 0);
        checkOutput("midrst_meas_valid", meas_valid, 0);
        checkOutput("midrst_locked", locked, 0);
        checkOutput("midrst_timeout", timeout, 0);
        applyStimulus(40, 0, 11, 39);

        // One strobe in four; the first crossing after reset produces no measurement.
        for (int p = 0; p < 6; p++) begin
            if (p >= 1) pushExp(50, 16384, -16384, p == 5, 1'b0);
            applyStimulus(50, 3, 0, 49);
        end
        checkOutput("lock_spaced", locked, 1);

        // The first zero after a negative sample is the last crossing; 100 strobes later it times out.
        pushExp(50, 16384, -16384, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) driveSample(0, 0);
        checkOutput("pre_timeout", timeout, 0);
        checkOutput("pre_timeout_locked", locked, 1);
        driveSample(0, 0);
        checkOutput("timeout_set", timeout, 1);
        checkOutput("timeout_locked", locked, 0);
        checkOutput("timeout_period", period, 50);
        checkOutput("timeout_peak_pos", peak_pos, 16384);
        checkOutput("timeout_peak_neg", peak_neg, -16384);

        // Restart: timeout stays set until the next measurement.
        applyStimulus(50, 0, 0, 49);
        applyStimulus(50, 0, 0, 49);
        checkOutput("timeout_sticky", timeout, 1);
        pushExp(50, 16384, -16384, 1'b0, 1'b0);
        applyStimulus(50, 0, 0, 4);
        checkOutput("timeout_cleared", timeout, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
